// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-cache refill and D-cache refill/write-back.
// Optional round-robin I-vs-D arbitration when MEM_ARB_RR_EN is defined.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module mem_arbiter #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int LINE_SIZE = `CACHE_LINE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_res,
    output logic [WORD_SIZE-1:0] i_res_addr,
    output logic [LINE_SIZE-1:0] i_res_data,
    input  logic                 d_read,
    input  logic [WORD_SIZE-1:0] d_addr,
    output logic                 d_res,
    output logic [WORD_SIZE-1:0] d_res_addr,
    output logic [LINE_SIZE-1:0] d_res_data,
    input  logic                 d_wenable,
    input  logic [WORD_SIZE-1:0] d_w_addr,
    input  logic [LINE_SIZE-1:0] d_w_data,
    output logic                 d_w_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [LINE_SIZE-1:0] mem_wdata,
    input  logic                 mem_res,
    input  logic [LINE_SIZE-1:0] mem_res_data,
    output logic                 busy
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [1:0] OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_DR = 2'd2, OWN_DW = 2'd3;

    state_t state, state_n;
    logic [1:0] owner, gnt_sel;
    logic ip_v, drp_v, dwp_v;
    logic [WORD_SIZE-1:0] ip_addr, drp_addr, dwp_addr;
    logic [LINE_SIZE-1:0] dwp_data;
    logic cand_i, cand_dr, cand_dw, cand_d, pick_d, grant, done;
    logic [WORD_SIZE-1:0] cand_i_addr, cand_dr_addr, cand_dw_addr, gnt_addr;
    logic [LINE_SIZE-1:0] cand_dw_data;
`ifdef MEM_ARB_RR_EN
    logic last_d;
`endif

    // Candidates include this cycle's pulses so an idle arbiter grants immediately.
    always_comb begin
        cand_i       = ip_v  | i_read;
        cand_dr      = drp_v | d_read;
        cand_dw      = dwp_v | d_wenable;
        cand_d       = cand_dr | cand_dw;
        cand_i_addr  = ip_v  ? ip_addr  : i_addr;
        cand_dr_addr = drp_v ? drp_addr : d_addr;
        cand_dw_addr = dwp_v ? dwp_addr : d_w_addr;
        cand_dw_data = dwp_v ? dwp_data : d_w_data;
        pick_d       = cand_d;
`ifdef MEM_ARB_RR_EN
        if (cand_i && cand_d) pick_d = !last_d;
`endif
        grant    = (state == IDLE) && (cand_i || cand_d);
        done     = (state == WAIT) && mem_res;
        gnt_sel  = OWN_I;
        gnt_addr = cand_i_addr;
        if (pick_d) begin
            gnt_sel  = cand_dw ? OWN_DW : OWN_DR;
            gnt_addr = cand_dw ? cand_dw_addr : cand_dr_addr;
        end
        state_n = state;
        if (grant) state_n = WAIT;
        if (done)  state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // A set slot ignores further pulses; it clears only on its own completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ip_v     <= 1'b0;
            drp_v    <= 1'b0;
            dwp_v    <= 1'b0;
            ip_addr  <= '0;
            drp_addr <= '0;
            dwp_addr <= '0;
            dwp_data <= '0;
        end else begin
            if (!ip_v && i_read) begin
                ip_v    <= 1'b1;
                ip_addr <= i_addr;
            end
            if (!drp_v && d_read) begin
                drp_v    <= 1'b1;
                drp_addr <= d_addr;
            end
            if (!dwp_v && d_wenable) begin
                dwp_v    <= 1'b1;
                dwp_addr <= d_w_addr;
                dwp_data <= d_w_data;
            end
            if (done && owner == OWN_I)  ip_v  <= 1'b0;
            if (done && owner == OWN_DR) drp_v <= 1'b0;
            if (done && owner == OWN_DW) dwp_v <= 1'b0;
        end
    end

    // mem_addr holds the granted address, which is echoed back on *_res_addr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= OWN_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_res      <= 1'b0;
            i_res_addr <= '0;
            i_res_data <= '0;
            d_res      <= 1'b0;
            d_res_addr <= '0;
            d_res_data <= '0;
            d_w_ack    <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            i_res   <= 1'b0;
            d_res   <= 1'b0;
            d_w_ack <= 1'b0;
            if (grant) begin
                owner    <= gnt_sel;
                mem_req  <= 1'b1;
                mem_we   <= (gnt_sel == OWN_DW);
                mem_addr <= gnt_addr;
                if (gnt_sel == OWN_DW) mem_wdata <= cand_dw_data;
            end
            if (done) begin
                case (owner)
                    OWN_I: begin
                        i_res      <= 1'b1;
                        i_res_addr <= mem_addr;
                        i_res_data <= mem_res_data;
                    end
                    OWN_DR: begin
                        d_res      <= 1'b1;
                        d_res_addr <= mem_addr;
                        d_res_data <= mem_res_data;
                    end
                    OWN_DW:  d_w_ack <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst)      last_d <= 1'b0;
        else if (done) last_d <= (owner != OWN_I);
    end
`endif

    assign busy = (state == WAIT);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model of
// its pending slots, priority and response routing.
module tb_mem_arbiter;
    localparam int W = 32;
    localparam int L = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_read = 0, d_read = 0, d_wenable = 0, mem_res = 0;
    logic [W-1:0] i_addr = '0, d_addr = '0, d_w_addr = '0;
    logic [L-1:0] d_w_data = '0, mem_res_data = '0;
    logic i_res, d_res, d_w_ack, mem_req, mem_we, busy;
    logic [W-1:0] i_res_addr, d_res_addr, mem_addr;
    logic [L-1:0] i_res_data, d_res_data, mem_wdata;

    mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(L)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_res(i_res), .i_res_addr(i_res_addr), .i_res_data(i_res_data),
        .d_read(d_read), .d_addr(d_addr), .d_res(d_res), .d_res_addr(d_res_addr), .d_res_data(d_res_data),
        .d_wenable(d_wenable), .d_w_addr(d_w_addr), .d_w_data(d_w_data), .d_w_ack(d_w_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_res(mem_res), .mem_res_data(mem_res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;

    // Reference model: sources 0=I read, 1=D read, 2=D write.
    bit           pv[3];
    logic [W-1:0] pa[3];
    logic [L-1:0] pwd;
    bit           m_busy, m_last_d;
    int           m_owner;
    logic         e_mem_req, e_mem_we, e_i_res, e_d_res, e_d_w_ack;
    logic [W-1:0] e_mem_addr, e_i_res_addr, e_d_res_addr;
    logic [L-1:0] e_mem_wdata, e_i_res_data, e_d_res_data;

    bit auto_mem = 0;
    int mem_cnt = 0;
    int req_seen = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin pv[s] = 0; pa[s] = '0; end
        pwd = '0; m_busy = 0; m_last_d = 0; m_owner = 0;
        e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
        e_i_res = 0; e_i_res_addr = '0; e_i_res_data = '0;
        e_d_res = 0; e_d_res_addr = '0; e_d_res_data = '0; e_d_w_ack = 0;
    endtask

    // One clock of the model from the inputs currently applied.
    task automatic model_step();
        bit req[3];
        logic [W-1:0] ra[3];
        int pick;
        if (!rst) begin model_reset(); return; end
        e_mem_req = 0; e_i_res = 0; e_d_res = 0; e_d_w_ack = 0;
        req[0] = i_read; req[1] = d_read; req[2] = d_wenable;
        ra[0] = i_addr;  ra[1] = d_addr;  ra[2] = d_w_addr;
        for (int s = 0; s < 3; s++)
            if (!pv[s] && req[s]) begin
                pv[s] = 1; pa[s] = ra[s];
                if (s == 2) pwd = d_w_data;
            end
        if (m_busy) begin
            if (mem_res) begin
                m_busy = 0;
                pv[m_owner] = 0;
                m_last_d = (m_owner != 0);
                if (m_owner == 0) begin e_i_res = 1; e_i_res_addr = pa[0]; e_i_res_data = mem_res_data; end
                else if (m_owner == 1) begin e_d_res = 1; e_d_res_addr = pa[1]; e_d_res_data = mem_res_data; end
                else e_d_w_ack = 1;
            end
        end else if (pv[0] || pv[1] || pv[2]) begin
            pick = pv[2] ? 2 : (pv[1] ? 1 : 0);
`ifdef MEM_ARB_RR_EN
            if (pv[0] && pick != 0 && m_last_d) pick = 0;
`endif
            m_busy = 1; m_owner = pick;
            e_mem_req = 1; e_mem_we = (pick == 2); e_mem_addr = pa[pick];
            if (pick == 2) e_mem_wdata = pwd;
        end
    endtask

    task automatic compare();
        chk("mem_req", 128'(mem_req), 128'(e_mem_req));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("mem_addr", 128'(mem_addr), 128'(e_mem_addr));
        chk("i_res", 128'(i_res), 128'(e_i_res));
        chk("d_res", 128'(d_res), 128'(e_d_res));
        chk("d_w_ack", 128'(d_w_ack), 128'(e_d_w_ack));
        chk("i_res_addr", 128'(i_res_addr), 128'(e_i_res_addr));
        chk("i_res_data", 128'(i_res_data), 128'(e_i_res_data));
        chk("d_res_addr", 128'(d_res_addr), 128'(e_d_res_addr));
        chk("d_res_data", 128'(d_res_data), 128'(e_d_res_data));
        if (e_mem_req) chk("mem_we", 128'(mem_we), 128'(e_mem_we));
        if (e_mem_req && e_mem_we) chk("mem_wdata", 128'(mem_wdata), 128'(e_mem_wdata));
        if (!rst) begin
            chk("rst_mem_we", 128'(mem_we), 128'(0));
            chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        end
    endtask

    // Advance one clock: model, edge, compare, then release pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
        if (mem_req) req_seen++;
        i_read = 0; d_read = 0; d_wenable = 0; mem_res = 0; rst = 1;
        if (auto_mem) begin
            if (e_mem_req) mem_cnt = $urandom_range(1, 4);
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_res = 1;
                    mem_res_data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                mem_res = 1;
                mem_res_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    logic [W-1:0] order[4];
    int n_got;

    initial begin
        model_reset();
        rst = 0;
        tick();
        chk("reset_busy", 128'(busy), 128'(0));

        // single I read
        i_read = 1; i_addr = 32'h100;
        tick();
        chk("ird_req", 128'(mem_req), 128'(1));
        chk("ird_addr", 128'(mem_addr), 128'(32'h100));
        chk("ird_we", 128'(mem_we), 128'(0));
        tick(); tick();
        mem_res = 1; mem_res_data = {16{8'hA5}};
        tick();
        chk("ird_res", 128'(i_res), 128'(1));
        chk("ird_res_addr", 128'(i_res_addr), 128'(32'h100));
        chk("ird_res_data", 128'(i_res_data), 128'({16{8'hA5}}));
        chk("ird_busy", 128'(busy), 128'(0));
        tick();

        // write before read
        d_wenable = 1; d_w_addr = 32'h200; d_w_data = {4{32'hDEADBEEF}};
        d_read = 1; d_addr = 32'h300;
        tick();
        chk("wbr_we", 128'(mem_we), 128'(1));
        chk("wbr_waddr", 128'(mem_addr), 128'(32'h200));
        chk("wbr_wdata", 128'(mem_wdata), 128'({4{32'hDEADBEEF}}));
        tick();
        mem_res = 1;
        tick();
        chk("wbr_ack", 128'(d_w_ack), 128'(1));
        chk("wbr_noreq", 128'(mem_req), 128'(0));
        tick();
        chk("wbr_rreq", 128'(mem_req), 128'(1));
        chk("wbr_raddr", 128'(mem_addr), 128'(32'h300));
        mem_res = 1; mem_res_data = {4{32'h12345678}};
        tick();
        chk("wbr_dres", 128'(d_res), 128'(1));
        chk("wbr_dres_addr", 128'(d_res_addr), 128'(32'h300));
        tick();

        // dropped duplicate
        req_seen = 0;
        i_read = 1; i_addr = 32'h100;
        tick();
        i_read = 1; i_addr = 32'h140;
        tick(); tick();
        mem_res = 1; mem_res_data = '1;
        tick();
        chk("dup_res_addr", 128'(i_res_addr), 128'(32'h100));
        tick(); tick(); tick();
        chk("dup_one_req", 128'(req_seen), 128'(1));

        // reset mid-flight
        d_read = 1; d_addr = 32'h480;
        tick();
        rst = 0;
        tick();
        chk("rmf_busy", 128'(busy), 128'(0));
        chk("rmf_mem_addr", 128'(mem_addr), 128'(0));
        mem_res = 1;
        tick();
        chk("rmf_dres", 128'(d_res), 128'(0));
        tick();

        // stray response while idle
        mem_res = 1;
        tick();
        chk("stray_busy", 128'(busy), 128'(0));
        tick();

        // I and D contend continuously over four transactions
        n_got = 0;
        for (int c = 0; c < 60 && n_got < 4; c++) begin
            i_read = 1; i_addr = 32'h400; d_read = 1; d_addr = 32'h500;
            if (busy && !mem_req) mem_res = 1;
            tick();
            if (mem_req) begin order[n_got] = mem_addr; n_got++; end
        end
        chk("tie_count", 128'(n_got), 128'(4));
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            chk("tie_order", 128'(order[k]), 128'((k % 2 == 0) ? 32'h500 : 32'h400));
`else
            chk("tie_order", 128'(order[k]), 128'(32'h500));
`endif
        end
        rst = 0;
        tick();

        // randomized traffic with a self-timed memory
        auto_mem = 1; mem_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            i_read    = ($urandom_range(0, 5) == 0);
            d_read    = ($urandom_range(0, 6) == 0);
            d_wenable = ($urandom_range(0, 8) == 0);
            i_addr    = $urandom; d_addr = $urandom; d_w_addr = $urandom;
            d_w_data  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 299) == 0) rst = 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's single backing-memory port between the I-cache refill path (`i_read`) and the D-cache refill/write-back path (`d_read`, `d_wenable`). It sits between `core` and `memory`, presenting the core-side cache ports unchanged. Only one memory transaction is in flight at a time. Requests are captured into per-source pending registers, granted by priority, and each memory response is routed back to the source that issued it.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE ``: address width.
- `LINE_SIZE`, default `` `CACHE_LINE_SIZE ``: data width of one cache-line transfer.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `i_read` in 1: I-side read request, one-cycle pulse.
- `i_addr` in WORD_SIZE: I-side read address.
- `i_res` out 1: I-side response pulse.
- `i_res_addr` out WORD_SIZE: address of the I-side response.
- `i_res_data` out LINE_SIZE: line data of the I-side response.
- `d_read` in 1: D-side read request, pulse.
- `d_addr` in WORD_SIZE: D-side read address.
- `d_res` out 1: D-side read response pulse.
- `d_res_addr` out WORD_SIZE: address of the D-side response.
- `d_res_data` out LINE_SIZE: line data of the D-side response.
- `d_wenable` in 1: D-side write-back request, pulse.
- `d_w_addr` in WORD_SIZE: write-back address.
- `d_w_data` in LINE_SIZE: write-back line data.
- `d_w_ack` out 1: write-back completion pulse.
- `mem_req` out 1: memory transaction start, one-cycle pulse.
- `mem_we` out 1: 1 = write, 0 = read; valid with `mem_req`.
- `mem_addr` out WORD_SIZE: memory address; valid with `mem_req`.
- `mem_wdata` out LINE_SIZE: memory write data; valid with `mem_req`.
- `mem_res` in 1: memory completion pulse (read data or write done).
- `mem_res_data` in LINE_SIZE: read data; valid with `mem_res`.
- `busy` out 1: a transaction is outstanding.

## Operation
- Three pending slots: IP (I read), DRP (D read), DWP (D write). Each slot holds a valid bit, the address and, for DWP only, the line data.
- Capture: a request pulse sets its slot when the slot is empty. A pulse into an already-set slot is dropped; the stored address and data are kept.
- A slot clears on the clock edge that samples `mem_res` for its transaction.
- State machine: IDLE and WAIT.
  - IDLE to WAIT: a candidate exists. Candidates are the set slots plus any request pulses arriving this cycle, so an idle arbiter grants a request in the cycle it arrives.
  - WAIT to IDLE: `mem_res` is sampled.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and driven in the cycle after the grant.
- Priority: DWP always wins over DRP, so the victim line is written before the refill.
- The I-versus-D choice between IP and the D side is set by `MEM_ARB_RR_EN` (see Configuration).
- Routing: a 2-bit `owner` register is loaded at grant. On `mem_res`, the arbiter registers the response onto the owner's outputs.
  - I owner: `i_res=1`, plus `i_res_addr` and `i_res_data`.
  - D read owner: `d_res=1`, plus `d_res_addr` and `d_res_data`.
  - D write owner: `d_w_ack=1`.
- `*_res_addr` returns the granted address, not memory's address.
- A `mem_res` sampled in IDLE is ignored and no output pulses.
- `busy` is 1 exactly while the state is WAIT.

## Timing
- Reset (`rst=0` at an edge): state becomes IDLE, all slots clear and `owner` clears. Every output becomes 0: `mem_req`, `mem_we`, `i_res`, `d_res`, `d_w_ack`, `busy`, and all address and data buses.
- Reset during WAIT abandons the transaction. A later `mem_res` is ignored.
- Requests pulsed while `rst=0` are not captured.
- Request in cycle t while IDLE: `mem_req` in cycle t+1.
- `mem_res` in cycle k: the owner's response pulse is in cycle k+1, and the state is IDLE in k+1.
- The next `mem_req` falls in cycle k+2 at the earliest. That is the minimum back-to-back spacing.
- A request pulsed in cycle k for the slot being completed is dropped, because the slot is still set. A request pulsed in cycle k+1 is captured.
- Response outputs are pulses: high for one cycle, then 0. Address and data buses hold their last value.
- Simultaneous `i_read`, `d_read` and `d_wenable` in IDLE: all three are captured and one is granted in that same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A 1-bit `last_d` register records whether the last completed grant was D-side (read or write).
  - When IP and a D slot compete, grant goes to the opposite side of `last_d`.
  - `last_d` resets to 0, so D wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority DWP > DRP > IP. The I side can starve.

## Test plan
- Single I read: `i_read`, `i_addr=0x100` in cycle 0 → `mem_req=1`, `mem_we=0`, `mem_addr=0x100` in cycle 1. `mem_res` with `mem_res_data=0xA5..A5` in cycle 4 → `i_res=1`, `i_res_addr=0x100`, data 0xA5..A5 in cycle 5. `d_res=0` throughout.
- Write before read: `d_wenable` (`d_w_addr=0x200`) and `d_read` (`d_addr=0x300`) in the same cycle → write issued first and `d_w_ack` on its response. The read is issued 2 cycles after the write's `mem_res`, and `d_res_addr=0x300`.
- Round-robin: with `MEM_ARB_RR_EN`, keep IP and DRP both set over 4 transactions → order D, I, D, I. Without the macro → every D request wins while DRP is set.
- Dropped duplicate: `i_read` at 0x100 then `i_read` at 0x140 while WAIT → exactly one `mem_req`, `mem_addr=0x100`, and one `i_res`.
- Reset mid-flight: `rst=0` for 1 cycle during WAIT, then `mem_res` → no response pulse, `busy=0`, and all outputs 0.
- Stray response: `mem_res=1` while IDLE with no pending requests → no output pulses and no state change.
